sdr_burst_reader: RTL and testbench
===================================

# sdr_burst_reader

Responder end of the `sdr_readstart` / `sdr_baseaddr` / `sdr_nelems` / `sdr_readdata` / `sdr_readend` handshake used by the ray-tracer front end. On a start pulse it fetches up to 64 consecutive 32-bit words from SDRAM through a pipelined Avalon-MM read master. It packs them into the 2048-bit `sdr_readdata` bus and pulses `sdr_readend` when the last word has landed. The block sits inside the system interconnect, between the exported conduit and the SDRAM/HPS bridge.

## Interface
- `NWORDS`, 64: capacity of `sdr_readdata` in 32-bit words; `sdr_readdata` width is 32*NWORDS.
- `MAX_OUTSTANDING`, 8: maximum accepted-but-unanswered reads; range 1..15.
- Clock and reset: one clock, `sdr_clk`. Reset `sdr_reset` is synchronous and active-high.
- `sdr_clk`  in  1  sole clock.
- `sdr_reset`  in  1  synchronous, active-high reset.
- `sdr_readstart`  in  1  one-cycle start request.
- `sdr_baseaddr`  in  32  byte address of word 0.
- `sdr_nelems`  in  30  number of words requested.
- `sdr_readdata`  out  2048  word i at bits [32*i +: 32].
- `sdr_readend`  out  1  one-cycle completion pulse.
- `sdr_busy`  out  1  high from the cycle after an accepted start through the `sdr_readend` cycle.
- `avm_address`  out  32  byte address.
- `avm_read`  out  1  read request.
- `avm_waitrequest`  in  1  slave stall.
- `avm_readdata`  in  32  response data.
- `avm_readdatavalid`  in  1  response strobe, in order.

## Operation
- FSM states:
  - IDLE: `sdr_readstart`=1 → LATCH. All other inputs are ignored.
  - LATCH:
    - Sample `sdr_baseaddr` into `base`.
    - Sample min(`sdr_nelems`, NWORDS) into `n`.
    - Zero `sdr_readdata`, `issued`, `recvd`.
    - If the clamped count is 0 → DONE; otherwise → ISSUE.
    - The initiator holds base/nelems valid from the cycle after `sdr_readstart` until `sdr_readend`. Only the LATCH-cycle values are used.
  - ISSUE:
    - `avm_read` = (`issued` < n) && (`issued` − `recvd` < MAX_OUTSTANDING).
    - `avm_address` = `base` + 4*`issued`, computed modulo 2^32 (wraps at top of address space).
    - A read is accepted when `avm_read` && !`avm_waitrequest`; `issued`++ on acceptance.
    - While `avm_waitrequest` is high, `avm_read` and `avm_address` stay stable. They do not drop because a response arrives in the same cycle.
    - When `issued` reaches n on acceptance → DRAIN.
  - DRAIN: `avm_read`=0. Wait for the remaining responses.
  - DONE: `sdr_readend`=1 for exactly one cycle → IDLE.
- Response capture, in ISSUE and DRAIN:
  - On `avm_readdatavalid`, write `avm_readdata` into word `recvd` and increment `recvd`.
  - When `recvd` becomes n → DONE. This can happen from ISSUE only if n responses arrive there, which is impossible before the last acceptance; otherwise from DRAIN.
  - `avm_readdatavalid` in IDLE, LATCH or DONE, or with `recvd` ≥ n, is ignored.
- Simultaneous acceptance and response in one cycle: outstanding count is unchanged. Both counters update.
- Words at index ≥ n read as 0 after completion.
- `sdr_readdata` holds its value after `sdr_readend` until the next LATCH.
- `sdr_readstart` while `sdr_busy` is ignored; no queueing.
- `sdr_nelems` > NWORDS: only NWORDS words are fetched, with no error indication.

## Timing
- Reset values:
  - State IDLE.
  - `sdr_readdata` = 0, `sdr_readend` = 0, `sdr_busy` = 0.
  - `avm_read` = 0, `avm_address` = 0.
  - Counters = 0.
- Reset mid-transfer: everything returns to IDLE on the next edge. Late `avm_readdatavalid` after reset is ignored; it must not corrupt the buffer.
- All outputs are registered.
- `sdr_busy` rises in LATCH, i.e. one cycle after `sdr_readstart`.
- Minimum latency with n=1, no wait states, response one cycle after acceptance:
  - start at cycle 0;
  - LATCH at cycle 1;
  - `avm_read` high at cycle 2;
  - `avm_readdatavalid` at cycle 3;
  - `sdr_readend` at cycle 4, with the word already visible on `sdr_readdata`.
- n=0: `sdr_readend` at cycle 2, with no Avalon traffic.
- Sustained throughput is one word per cycle when `avm_waitrequest`=0 and response latency ≤ MAX_OUTSTANDING.

## Test plan
- Transfer of 15 words:
  - Stimulus: base=0x0000_0100, nelems=15, no waitrequest, 1-cycle response latency, memory word k = 0xA000_0000+k.
  - Required: addresses 0x100..0x138 in steps of 4; words 0..14 = 0xA000_0000..0xA000_000E; words 15..63 = 0; exactly one `sdr_readend` pulse at cycle 18.
- Backpressure and outstanding limit:
  - Stimulus: nelems=20, `avm_waitrequest` random 50%, response latency 12.
  - Required: `avm_read`/`avm_address` stable while stalled; `issued`−`recvd` never exceeds 8; data is correct.
- Zero and overflow counts:
  - nelems=0 → `sdr_readend` 2 cycles after start, no `avm_read`.
  - nelems=1000 → exactly 64 reads, buffer filled.
- Address wrap: base=0xFFFF_FFF8, nelems=4 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Start while busy and back-to-back transfers:
  - A second `sdr_readstart` mid-transfer is ignored.
  - A new start the cycle after `sdr_readend` clears the old buffer in LATCH and completes normally.
- Reset mid-transfer:
  - Stimulus: assert `sdr_reset` after 5 of 15 responses, then inject 3 stray `avm_readdatavalid`.
  - Required: all outputs 0, state IDLE; a subsequent start completes correctly.

Source files
------------

// File: rtl/sdr_burst_reader.sv
// Burst reader: on a start pulse, fetch up to NWORDS consecutive 32-bit words
// over a pipelined Avalon-MM read master and present them on a wide bus.
module sdr_burst_reader #(
  parameter int NWORDS          = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  sdr_clk,
  input  logic                  sdr_reset,
  input  logic                  sdr_readstart,
  input  logic [31:0]           sdr_baseaddr,
  input  logic [29:0]           sdr_nelems,
  output logic [32*NWORDS-1:0]  sdr_readdata,
  output logic                  sdr_readend,
  output logic                  sdr_busy,
  output logic [31:0]           avm_address,
  output logic                  avm_read,
  input  logic                  avm_waitrequest,
  input  logic [31:0]           avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int CW = $clog2(NWORDS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    ISSUE,
    DRAIN,
    DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [31:0]     base_reg, base_next;
  logic [CW-1:0]   n_reg, n_next;
  logic [CW-1:0]   issued_reg, issued_next;
  logic [CW-1:0]   recvd_reg, recvd_next;
  logic            read_reg, read_next;
  logic [31:0]     addr_reg, addr_next;
  logic            readend_reg;
  logic            busy_reg;

  logic            accept;
  logic            capture;
  logic            clear_buf;
  logic [CW-1:0]   clamp;
  logic [CW-1:0]   outstanding_next;

  // Oversized requests are silently truncated to the buffer capacity.
  assign clamp = (sdr_nelems > 30'(NWORDS)) ? CW'(NWORDS) : sdr_nelems[CW-1:0];

  assign accept  = (state_reg == ISSUE) && read_reg && !avm_waitrequest;
  assign capture = ((state_reg == ISSUE) || (state_reg == DRAIN)) &&
                   avm_readdatavalid && (recvd_reg < n_reg);

  assign outstanding_next = issued_next - recvd_next;

  always_comb begin
    state_next  = state_reg;
    base_next   = base_reg;
    n_next      = n_reg;
    issued_next = issued_reg;
    recvd_next  = recvd_reg;
    read_next   = 1'b0;
    addr_next   = addr_reg;
    clear_buf   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sdr_readstart) begin
          state_next = LATCH;
        end
      end

      LATCH: begin
        base_next   = sdr_baseaddr;
        n_next      = clamp;
        issued_next = '0;
        recvd_next  = '0;
        clear_buf   = 1'b1;
        addr_next   = sdr_baseaddr;
        if (clamp == '0) begin
          state_next = DONE;
        end else begin
          state_next = ISSUE;
          read_next  = 1'b1;
        end
      end

      ISSUE, DRAIN: begin
        if (accept) begin
          issued_next = issued_reg + 1'b1;
        end
        if (capture) begin
          recvd_next = recvd_reg + 1'b1;
        end
        if (recvd_next == n_reg) begin
          state_next = DONE;
        end else if (issued_next == n_reg) begin
          state_next = DRAIN;
        end
        // Request line is computed from post-update counters so it is
        // registered; a stalled request can only gain headroom, never lose it.
        read_next = (state_next == ISSUE) && (issued_next < n_reg) &&
                    (32'(outstanding_next) < 32'(MAX_OUTSTANDING));
        addr_next = base_reg + (32'(issued_next) << 2);
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge sdr_clk) begin
    if (sdr_reset) begin
      state_reg   <= IDLE;
      base_reg    <= '0;
      n_reg       <= '0;
      issued_reg  <= '0;
      recvd_reg   <= '0;
      read_reg    <= 1'b0;
      addr_reg    <= '0;
      readend_reg <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      base_reg    <= base_next;
      n_reg       <= n_next;
      issued_reg  <= issued_next;
      recvd_reg   <= recvd_next;
      read_reg    <= read_next;
      addr_reg    <= addr_next;
      readend_reg <= (state_next == DONE);
      busy_reg    <= (state_next != IDLE);
    end
  end

  // One register per word; only the slot addressed by recvd is written.
  genvar gi;
  generate
    for (gi = 0; gi < NWORDS; gi++) begin : g_word
      logic [31:0] word_reg;

      always_ff @(posedge sdr_clk) begin
        if (sdr_reset) begin
          word_reg <= '0;
        end else if (clear_buf) begin
          word_reg <= '0;
        end else if (capture && (recvd_reg == CW'(gi))) begin
          word_reg <= avm_readdata;
        end
      end

      assign sdr_readdata[32*gi +: 32] = word_reg;
    end
  endgenerate

  assign sdr_readend = readend_reg;
  assign sdr_busy    = busy_reg;
  assign avm_read    = read_reg;
  assign avm_address = addr_reg;

endmodule

// File: tb/tb_sdr_burst_reader.sv
// Randomised bench for sdr_burst_reader: an Avalon slave model with latency and
// backpressure feeds the DUT, and a per-cycle monitor checks it against the rules.
module tb_sdr_burst_reader;

  localparam int NW   = 64;
  localparam int MAXO = 8;

  logic              clk = 1'b0;
  logic              sdr_reset;
  logic              sdr_readstart;
  logic [31:0]       sdr_baseaddr;
  logic [29:0]       sdr_nelems;
  logic [32*NW-1:0]  sdr_readdata;
  logic              sdr_readend;
  logic              sdr_busy;
  logic [31:0]       avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  sdr_burst_reader #(.NWORDS(NW), .MAX_OUTSTANDING(MAXO)) dut (
    .sdr_clk           (clk),
    .sdr_reset         (sdr_reset),
    .sdr_readstart     (sdr_readstart),
    .sdr_baseaddr      (sdr_baseaddr),
    .sdr_nelems        (sdr_nelems),
    .sdr_readdata      (sdr_readdata),
    .sdr_readend       (sdr_readend),
    .sdr_busy          (sdr_busy),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Transfer context shared between the driver and the monitor.
  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t       rq[$];
  logic [31:0] addr_log[$];
  logic [31:0] exp_base;
  int          exp_n, acc_count, resp_count, pulses, read_cycles, end_cyc;
  int          cur_lat, wait_pct, mem_mode, stray_left;
  logic [31:0] mem_seed;
  bit          done, xfer_active, prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memf(input logic [31:0] addr);
    if (mem_mode == 1) return 32'hA000_0000 + ((addr - 32'h100) >> 2);
    return {addr[15:0], addr[31:16]} ^ mem_seed;
  endfunction

  function automatic logic [31:0] exp_word(input int k);
    if (k < exp_n) return memf(exp_base + 32'(4 * k));
    return 32'h0;
  endfunction

  // Slave model and per-cycle compare process.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      if (sdr_reset) begin
        rq.delete();
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        prev_stall        = 1'b0;
        continue;
      end
      if (prev_stall) begin
        chk("stall_read", 32'(avm_read), 32'd1);
        chk("stall_addr", avm_address, prev_addr);
      end
      if (avm_read) begin
        read_cycles++;
        chk("read_while_busy", 32'(sdr_busy), 32'd1);
        chk("outstanding_room", 32'(acc_count - resp_count < MAXO), 32'd1);
      end
      if (sdr_readend) begin
        chk("end_in_xfer", 32'(xfer_active), 32'd1);
        chk("end_busy", 32'(sdr_busy), 32'd1);
        chk("end_resp_count", 32'(resp_count), 32'(exp_n));
        for (int k = 0; k < NW; k++) begin
          chk($sformatf("word%0d", k), sdr_readdata[32*k +: 32], exp_word(k));
        end
        done    = 1'b1;
        end_cyc = cyc;
        pulses++;
      end
      avm_readdatavalid = 1'b0;
      if (stray_left > 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = 32'hDEAD_0000 + 32'(stray_left);
        stray_left--;
      end else if (rq.size() > 0 && rq[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rq[0].data;
        void'(rq.pop_front());
        resp_count++;
      end
      avm_waitrequest = avm_read ? ($urandom_range(99) < wait_pct) : 1'($urandom_range(1));
      if (avm_read && !avm_waitrequest) begin
        chk("read_in_xfer", 32'(xfer_active), 32'd1);
        chk("accept_addr", avm_address, exp_base + 32'(4 * acc_count));
        chk("accept_within_n", 32'(acc_count < exp_n), 32'd1);
        rq.push_back('{due: cyc + cur_lat, data: memf(avm_address)});
        addr_log.push_back(avm_address);
        acc_count++;
      end
      prev_stall = avm_read && avm_waitrequest;
      prev_addr  = avm_address;
    end
  end

  task automatic run_transfer(input logic [31:0] base, input int nelems, input int lat,
                              input int wpct, input int mode, input int dup_at,
                              input bit settle, output int lat_cycles);
    int s;
    @(posedge clk); #3;
    chk("busy_before_start", 32'(sdr_busy), 32'd0);
    exp_base = base; exp_n = (nelems > NW) ? NW : nelems;
    acc_count = 0; resp_count = 0; pulses = 0; done = 1'b0; read_cycles = 0;
    addr_log.delete();
    cur_lat = lat; wait_pct = wpct; mem_mode = mode; mem_seed = $urandom;
    xfer_active   = 1'b1;
    sdr_baseaddr  = base;
    sdr_nelems    = 30'(nelems);
    sdr_readstart = 1'b1;
    s = cyc;
    @(posedge clk); #3;
    sdr_readstart = 1'b0;
    chk("busy_in_latch", 32'(sdr_busy), 32'd1);
    forever begin
      if (done) break;
      if (cyc - s > 3000) begin
        chk("timeout_readend", 32'd0, 32'd1);
        break;
      end
      @(posedge clk); #3;
      sdr_readstart = (dup_at > 0) && (cyc - s == dup_at);
    end
    sdr_readstart = 1'b0;
    lat_cycles = end_cyc - s;
    chk("accept_count", 32'(acc_count), 32'(exp_n));
    if (settle) begin
      repeat (3) @(posedge clk);
      #3;
      chk("single_readend", 32'(pulses), 32'd1);
      chk("busy_after_end", 32'(sdr_busy), 32'd0);
      chk("hold_word0", sdr_readdata[31:0], exp_word(0));
      chk("hold_last", sdr_readdata[32*(NW-1) +: 32], exp_word(NW - 1));
      xfer_active = 1'b0;
    end
    $display("xfer base=%h nelems=%0d lat=%0d wait=%0d%% -> readend after %0d cycles",
             base, nelems, lat, wpct, lat_cycles);
  endtask

  int l;

  initial begin
    xfer_active = 1'b0; stray_left = 0; wait_pct = 0; mem_mode = 0; mem_seed = 0;
    exp_base = 0; exp_n = 0; acc_count = 0; resp_count = 0; pulses = 0;
    sdr_reset = 1'b1; sdr_readstart = 1'b0; sdr_baseaddr = '0; sdr_nelems = '0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_readend", 32'(sdr_readend), 32'd0);
    chk("rst_busy", 32'(sdr_busy), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", avm_address, 32'd0);
    chk("rst_data", 32'(|sdr_readdata), 32'd0);
    sdr_reset = 1'b0;

    // 15 words, no stalls, 1-cycle latency.
    run_transfer(32'h0000_0100, 15, 1, 0, 1, 0, 1'b1, l);
    chk("t15_latency", 32'(l), 32'd18);
    chk("t15_naddr", 32'(addr_log.size()), 32'd15);
    chk("t15_addr_first", addr_log[0], 32'h0000_0100);
    chk("t15_addr_last", addr_log[14], 32'h0000_0138);
    chk("t15_word14", sdr_readdata[32*14 +: 32], 32'hA000_000E);
    chk("t15_word15", sdr_readdata[32*15 +: 32], 32'h0);

    run_transfer(32'h0000_0040, 1, 1, 0, 0, 0, 1'b1, l);
    chk("n1_latency", 32'(l), 32'd4);

    // Backpressure with long latency exercises the outstanding limit.
    run_transfer(32'h0001_0000, 20, 12, 50, 0, 0, 1'b1, l);

    run_transfer(32'h0000_2000, 0, 1, 0, 0, 0, 1'b1, l);
    chk("n0_latency", 32'(l), 32'd2);
    chk("n0_no_read", 32'(read_cycles), 32'd0);

    run_transfer(32'h0040_0000, 1000, 2, 10, 0, 0, 1'b1, l);

    run_transfer(32'hFFFF_FFF8, 4, 1, 0, 0, 0, 1'b1, l);
    chk("wrap_a0", addr_log[0], 32'hFFFF_FFF8);
    chk("wrap_a1", addr_log[1], 32'hFFFF_FFFC);
    chk("wrap_a2", addr_log[2], 32'h0000_0000);
    chk("wrap_a3", addr_log[3], 32'h0000_0004);

    // Second start mid-transfer must be ignored.
    run_transfer(32'h0000_3000, 30, 3, 20, 0, 6, 1'b1, l);

    // Back-to-back: new start the cycle after readend.
    run_transfer(32'h0000_5000, 20, 2, 0, 0, 0, 1'b0, l);
    run_transfer(32'h0000_6000, 5, 1, 0, 0, 0, 1'b1, l);

    // Reset after 5 of 15 responses, then stray responses.
    @(posedge clk); #3;
    exp_base = 32'h0000_7000; exp_n = 15; acc_count = 0; resp_count = 0; pulses = 0;
    done = 1'b0; cur_lat = 1; wait_pct = 0; mem_mode = 0; xfer_active = 1'b1;
    addr_log.delete();
    sdr_baseaddr = exp_base; sdr_nelems = 30'd15; sdr_readstart = 1'b1;
    @(posedge clk); #3;
    sdr_readstart = 1'b0;
    for (int i = 0; i < 100 && resp_count < 5; i++) begin
      @(posedge clk); #3;
    end
    chk("rst_mid_reached", 32'(resp_count >= 5), 32'd1);
    sdr_reset = 1'b1;
    @(posedge clk); #3;
    sdr_reset   = 1'b0;
    xfer_active = 1'b0;
    chk("midrst_readend", 32'(sdr_readend), 32'd0);
    chk("midrst_busy", 32'(sdr_busy), 32'd0);
    chk("midrst_read", 32'(avm_read), 32'd0);
    chk("midrst_addr", avm_address, 32'd0);
    chk("midrst_data", 32'(|sdr_readdata), 32'd0);
    stray_left = 3;
    repeat (5) @(posedge clk);
    #3;
    chk("stray_data", 32'(|sdr_readdata), 32'd0);
    chk("stray_busy", 32'(sdr_busy), 32'd0);
    chk("stray_pulses", 32'(pulses), 32'd0);
    run_transfer(32'h0000_8000, 15, 1, 0, 0, 0, 1'b1, l);
    chk("post_rst_latency", 32'(l), 32'd18);

    // Randomised transfers.
    for (int t = 0; t < 10; t++) begin
      run_transfer({$urandom_range(32'h3FFF_FFFF), 2'b00}, int'($urandom_range(70)),
                   int'($urandom_range(14, 1)), int'($urandom_range(70)), 0,
                   0, 1'b1, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
